// File: rtl/snoop_sched_4.sv
// Flat 4-way round-robin scheduler that routes snooper writes to one packet buffer at a time
// and logs every finished assignment in an order FIFO for in-order draining.
module snoop_sched_4 #(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned ADDR_WIDTH      = 10,
    parameter int unsigned ORDER_DEPTH_LOG = 3,
    parameter bit          PESSIMISTIC     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    input  logic                  done,
    output logic                  mem_ready,
    input  logic [3:0]            mem_ready_in,
    output logic [ADDR_WIDTH-1:0] wr_addr_out,
    output logic [DATA_WIDTH-1:0] wr_data_out,
    output logic [3:0]            wr_en_out,
    output logic [3:0]            done_out,
    output logic [1:0]            sel,
    output logic [1:0]            order_id,
    output logic                  order_valid,
    input  logic                  order_rd_en,
    output logic [15:0]           drop_count
);

    localparam int unsigned Depth = 1 << ORDER_DEPTH_LOG;
    localparam int unsigned CntW  = ORDER_DEPTH_LOG + 1;

    typedef enum logic {StIdle, StActive} state_e;

    state_e                     state_q, state_d;
    logic [1:0]                 sel_q, sel_d;
    logic [1:0]                 rr_ptr_q, rr_ptr_d;
    logic [1:0]                 holdoff_q [4];
    logic [1:0]                 holdoff_d [4];
    logic [1:0]                 fifo_q [Depth];
    logic [ORDER_DEPTH_LOG-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]            cnt_q, cnt_next;
    logic [15:0]                drop_q;

    logic       push, pop, can_select, found;
    logic [3:0] cand;
    logic [1:0] rr_scan, pick, idx;

    assign push       = (state_q == StActive) && done;
    assign pop        = order_rd_en && (cnt_q != '0);
    assign cnt_next   = cnt_q + CntW'(push) - CntW'(pop);
    assign can_select = cnt_next < CntW'(Depth);
    // A finishing buffer hands priority to its successor within the same cycle.
    assign rr_scan    = push ? sel_q + 2'd1 : rr_ptr_q;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cand[i] = mem_ready_in[i] && (holdoff_q[i] == 2'd0) && !(push && (sel_q == 2'(i)));
        end
    end

    // Scan from the farthest offset down so the nearest candidate wins.
    always_comb begin
        pick = rr_scan;
        idx  = rr_scan;
        for (int k = 3; k >= 0; k--) begin
            idx = rr_scan + 2'(k);
            if (cand[idx]) begin
                pick = idx;
            end
        end
    end

    assign found = |cand;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        for (int i = 0; i < 4; i++) begin
            holdoff_d[i] = (holdoff_q[i] != 2'd0) ? holdoff_q[i] - 2'd1 : 2'd0;
        end
        unique case (state_q)
            StIdle: begin
                if (found && can_select) begin
                    state_d = StActive;
                    sel_d   = pick;
                end
            end
            StActive: begin
                if (done) begin
                    rr_ptr_d = sel_q + 2'd1;
                    if (PESSIMISTIC) begin
                        holdoff_d[sel_q] = 2'd2;
                    end
                    if (found && can_select) begin
                        sel_d = pick;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            sel_q    <= 2'd0;
            rr_ptr_q <= 2'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            drop_q   <= 16'd0;
            for (int i = 0; i < 4; i++) begin
                holdoff_q[i] <= 2'd0;
            end
            for (int i = 0; i < int'(Depth); i++) begin
                fifo_q[i] <= 2'd0;
            end
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_next;
            for (int i = 0; i < 4; i++) begin
                holdoff_q[i] <= holdoff_d[i];
            end
            if (push) begin
                fifo_q[wr_ptr_q] <= sel_q;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if ((state_q == StIdle) && done && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    always_comb begin
        wr_en_out = 4'd0;
        done_out  = 4'd0;
        if (state_q == StActive) begin
            wr_en_out = 4'(wr_en) << sel_q;
            done_out  = 4'(done) << sel_q;
        end
    end

    assign mem_ready   = (state_q == StActive);
    assign wr_addr_out = wr_addr;
    assign wr_data_out = wr_data;
    assign sel         = sel_q;
    assign order_id    = fifo_q[rd_ptr_q];
    assign order_valid = (cnt_q != '0);
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_snoop_sched_4.sv
// Self-checking bench for snoop_sched_4: directed scenarios on three parameterisations plus a
// randomized run checked against a queue-based reference model.
module tb_snoop_sched_4;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        wr_en, done, order_rd_en;
    logic [3:0]  mem_ready_in;

    logic        mem_ready_a, order_valid_a, mem_ready_p, order_valid_p, mem_ready_s, order_valid_s;
    logic [9:0]  wr_addr_out_a, wr_addr_out_p, wr_addr_out_s;
    logic [63:0] wr_data_out_a, wr_data_out_p, wr_data_out_s;
    logic [3:0]  wr_en_out_a, done_out_a, wr_en_out_p, done_out_p, wr_en_out_s, done_out_s;
    logic [1:0]  sel_a, order_id_a, sel_p, order_id_p, sel_s, order_id_s;
    logic [15:0] drop_count_a, drop_count_p, drop_count_s;

    int total = 0;
    int bad   = 0;

    // Reference model state for the default instance.
    int m_owner;
    int m_rr;
    int m_drops;
    int m_q[$];

    always #5 clk = ~clk;

    snoop_sched_4 dut_a (
        .clk(clk), .rst(rst), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .done(done),
        .mem_ready(mem_ready_a), .mem_ready_in(mem_ready_in), .wr_addr_out(wr_addr_out_a),
        .wr_data_out(wr_data_out_a), .wr_en_out(wr_en_out_a), .done_out(done_out_a),
        .sel(sel_a), .order_id(order_id_a), .order_valid(order_valid_a),
        .order_rd_en(order_rd_en), .drop_count(drop_count_a)
    );

    snoop_sched_4 #(.PESSIMISTIC(1'b1)) dut_p (
        .clk(clk), .rst(rst), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .done(done),
        .mem_ready(mem_ready_p), .mem_ready_in(mem_ready_in), .wr_addr_out(wr_addr_out_p),
        .wr_data_out(wr_data_out_p), .wr_en_out(wr_en_out_p), .done_out(done_out_p),
        .sel(sel_p), .order_id(order_id_p), .order_valid(order_valid_p),
        .order_rd_en(order_rd_en), .drop_count(drop_count_p)
    );

    snoop_sched_4 #(.ORDER_DEPTH_LOG(1)) dut_s (
        .clk(clk), .rst(rst), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .done(done),
        .mem_ready(mem_ready_s), .mem_ready_in(mem_ready_in), .wr_addr_out(wr_addr_out_s),
        .wr_data_out(wr_data_out_s), .wr_en_out(wr_en_out_s), .done_out(done_out_s),
        .sel(sel_s), .order_id(order_id_s), .order_valid(order_valid_s),
        .order_rd_en(order_rd_en), .drop_count(drop_count_s)
    );

    function automatic int m_pick(input logic [3:0] rdy, input int start, input int excl);
        for (int k = 0; k < 4; k++) begin
            int b = (start + k) % 4;
            if (rdy[b] && b != excl) return b;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_rr    = 0;
        m_drops = 0;
        m_q.delete();
    endfunction

    function automatic void model_step(input logic [3:0] rdy, input logic dn, input logic rd);
        bit push  = (m_owner >= 0) && dn;
        bit pop   = rd && (m_q.size() > 0);
        int occ   = m_q.size() + int'(push) - int'(pop);
        int start = push ? (m_owner + 1) % 4 : m_rr;
        int excl  = push ? m_owner : -1;
        int p     = m_pick(rdy, start, excl);
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(m_owner);
        if (m_owner < 0) begin
            if (dn && m_drops < 65535) m_drops++;
            if (p >= 0 && occ < 8) m_owner = p;
        end else if (dn) begin
            m_rr    = start;
            m_owner = (p >= 0 && occ < 8) ? p : -1;
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; wr_en = 1'b0; done = 1'b0; mem_ready_in = 4'd0; order_rd_en = 1'b0;
        wr_addr = 10'd0; wr_data = 64'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        wr_en = 1'b1;
        #1;
        total++; if (mem_ready_a !== 1'b0) begin bad++; $display("FAIL reset_mem_ready got=%0b exp=0", mem_ready_a); end
        total++; if (sel_a !== 2'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", sel_a); end
        total++; if (wr_en_out_a !== 4'd0) begin bad++; $display("FAIL reset_wr_en_out got=%0h exp=0", wr_en_out_a); end
        total++; if (done_out_a !== 4'd0) begin bad++; $display("FAIL reset_done_out got=%0h exp=0", done_out_a); end
        total++; if (order_valid_a !== 1'b0) begin bad++; $display("FAIL reset_order_valid got=%0b exp=0", order_valid_a); end
        total++; if (order_id_a !== 2'd0) begin bad++; $display("FAIL reset_order_id got=%0d exp=0", order_id_a); end
        total++; if (drop_count_a !== 16'd0) begin bad++; $display("FAIL reset_drop_count got=%0d exp=0", drop_count_a); end
        wr_en = 1'b0;
    endtask

    task automatic test_round_robin();
        int exp_q[5] = '{0, 1, 2, 3, 0};
        do_reset();
        mem_ready_in = 4'hF;
        #1;
        total++; if (mem_ready_a !== 1'b0) begin bad++; $display("FAIL rr_latency got=%0b exp=0", mem_ready_a); end
        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                wr_en = 1'b1; done = (c == 9);
                wr_addr = 10'($urandom); wr_data = {$urandom, $urandom};
                #1;
                total++; if (mem_ready_a !== 1'b1 || sel_a !== 2'(p % 4)) begin bad++; $display("FAIL rr_sel pkt=%0d got=%0b/%0d exp=1/%0d", p, mem_ready_a, sel_a, p % 4); end
                total++; if (wr_en_out_a !== (4'b0001 << (p % 4))) begin bad++; $display("FAIL rr_wr_en_out got=%0h exp=%0h", wr_en_out_a, 4'b0001 << (p % 4)); end
                total++; if (done_out_a !== (done ? (4'b0001 << (p % 4)) : 4'd0)) begin bad++; $display("FAIL rr_done_out got=%0h", done_out_a); end
            end
        end
        @(negedge clk);
        wr_en = 1'b0; done = 1'b0; mem_ready_in = 4'd0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (order_valid_a !== 1'b1 || order_id_a !== 2'(exp_q[i])) begin bad++; $display("FAIL rr_order idx=%0d got=%0b/%0d exp=1/%0d", i, order_valid_a, order_id_a, exp_q[i]); end
            order_rd_en = 1'b1;
            @(negedge clk);
        end
        order_rd_en = 1'b0;
        #1;
        total++; if (order_valid_a !== 1'b0) begin bad++; $display("FAIL rr_order_empty got=%0b exp=0", order_valid_a); end
    endtask

    task automatic test_ready_drop();
        int exp_s[5] = '{0, 1, 2, 0, 3};
        do_reset();
        mem_ready_in = 4'b0111;
        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (c == 0 && p > 0) mem_ready_in[exp_s[p-1]] = 1'b0;
                if (c == 0 && p == 2) mem_ready_in[0] = 1'b1;
                if (c == 0 && p == 3) mem_ready_in[3] = 1'b1;
                wr_en = 1'b1; done = (c == 2);
                #1;
                total++; if (mem_ready_a !== 1'b1 || sel_a !== 2'(exp_s[p])) begin bad++; $display("FAIL drop_seq pkt=%0d got=%0b/%0d exp=1/%0d", p, mem_ready_a, sel_a, exp_s[p]); end
            end
        end
        @(negedge clk);
        wr_en = 1'b0; done = 1'b0; mem_ready_in[3] = 1'b0;
        #1;
        total++; if (mem_ready_a !== 1'b0) begin bad++; $display("FAIL drop_idle got=%0b exp=0", mem_ready_a); end
        @(negedge clk);
        mem_ready_in[2] = 1'b1;
        #1;
        total++; if (mem_ready_a !== 1'b0) begin bad++; $display("FAIL drop_c_latency got=%0b exp=0", mem_ready_a); end
        @(negedge clk);
        #1;
        total++; if (mem_ready_a !== 1'b1 || sel_a !== 2'd2) begin bad++; $display("FAIL drop_c_sel got=%0b/%0d exp=1/2", mem_ready_a, sel_a); end
    endtask

    task automatic test_pessimistic();
        int  lo_p = 0;
        int  lo_a = 0;
        bit  hi_p = 0;
        bit  hi_a = 0;
        do_reset();
        mem_ready_in = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            wr_en = 1'b1; done = (c == 2);
            #1;
            total++; if (mem_ready_p !== 1'b1 || sel_p !== 2'd0) begin bad++; $display("FAIL pess_active got=%0b/%0d exp=1/0", mem_ready_p, sel_p); end
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            wr_en = 1'b0; done = 1'b0;
            #1;
            if (!hi_p) begin if (mem_ready_p) hi_p = 1; else lo_p++; end
            if (!hi_a) begin if (mem_ready_a) hi_a = 1; else lo_a++; end
        end
        // Two holdoff cycles on top of the single cycle the plain scheduler already spends idle.
        total++; if (lo_p != 3) begin bad++; $display("FAIL pess_low_cycles got=%0d exp=3", lo_p); end
        total++; if (lo_a != 1) begin bad++; $display("FAIL plain_low_cycles got=%0d exp=1", lo_a); end
        total++; if (sel_p !== 2'd0) begin bad++; $display("FAIL pess_resel got=%0d exp=0", sel_p); end
    endtask

    task automatic test_capacity();
        do_reset();
        mem_ready_in = 4'hF;
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                wr_en = 1'b1; done = (c == 1);
                #1;
                total++; if (mem_ready_s !== 1'b1 || sel_s !== 2'(p)) begin bad++; $display("FAIL cap_sel pkt=%0d got=%0b/%0d exp=1/%0d", p, mem_ready_s, sel_s, p); end
            end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wr_en = 1'b0; done = 1'b0;
            #1;
            total++; if (mem_ready_s !== 1'b0) begin bad++; $display("FAIL cap_full_hold cyc=%0d got=%0b exp=0", i, mem_ready_s); end
        end
        total++; if (order_valid_s !== 1'b1 || order_id_s !== 2'd0) begin bad++; $display("FAIL cap_head got=%0b/%0d exp=1/0", order_valid_s, order_id_s); end
        order_rd_en = 1'b1;
        @(negedge clk);
        order_rd_en = 1'b0;
        #1;
        total++; if (mem_ready_s !== 1'b1 || sel_s !== 2'd2) begin bad++; $display("FAIL cap_after_pop got=%0b/%0d exp=1/2", mem_ready_s, sel_s); end
        total++; if (order_id_s !== 2'd1) begin bad++; $display("FAIL cap_pop_advance got=%0d exp=1", order_id_s); end
    endtask

    task automatic test_drops();
        do_reset();
        mem_ready_in = 4'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            done = 1'b1; wr_en = 1'b1;
            #1;
            total++; if (done_out_a !== 4'd0 || wr_en_out_a !== 4'd0) begin bad++; $display("FAIL drop_route got=%0h/%0h exp=0/0", done_out_a, wr_en_out_a); end
            @(negedge clk);
            done = 1'b0; wr_en = 1'b0;
        end
        #1;
        total++; if (drop_count_a !== 16'd3) begin bad++; $display("FAIL drop_count got=%0d exp=3", drop_count_a); end
        total++; if (mem_ready_a !== 1'b0) begin bad++; $display("FAIL drop_mem_ready got=%0b exp=0", mem_ready_a); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        mem_ready_in = 4'hF;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            wr_en = 1'b1; done = (c == 1) || (c == 3);
        end
        #1;
        total++; if (sel_a !== 2'd2 || wr_en_out_a !== 4'b0100) begin bad++; $display("FAIL mid_pre got=%0d/%0h exp=2/4", sel_a, wr_en_out_a); end
        done = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        total++; if (mem_ready_a !== 1'b0 || sel_a !== 2'd0) begin bad++; $display("FAIL mid_state got=%0b/%0d exp=0/0", mem_ready_a, sel_a); end
        total++; if (wr_en_out_a !== 4'd0 || done_out_a !== 4'd0) begin bad++; $display("FAIL mid_route got=%0h/%0h exp=0/0", wr_en_out_a, done_out_a); end
        total++; if (order_valid_a !== 1'b0 || order_id_a !== 2'd0) begin bad++; $display("FAIL mid_fifo got=%0b/%0d exp=0/0", order_valid_a, order_id_a); end
        total++; if (drop_count_a !== 16'd0) begin bad++; $display("FAIL mid_drops got=%0d exp=0", drop_count_a); end
        rst = 1'b0;
        @(negedge clk);
        #1;
        total++; if (mem_ready_a !== 1'b1 || sel_a !== 2'd0) begin bad++; $display("FAIL mid_first_sel got=%0b/%0d exp=1/0", mem_ready_a, sel_a); end
        wr_en = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] exp_w, exp_d;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            mem_ready_in = ((cyc % 50) < 10) ? 4'd0 : 4'($urandom);
            wr_en        = 1'($urandom);
            wr_addr      = 10'($urandom);
            wr_data      = {$urandom, $urandom};
            if (m_owner >= 0) done = ($urandom % 4 == 0);
            else done = (mem_ready_in == 4'd0) && ($urandom % 4 == 0);
            order_rd_en  = (cyc < 300) ? ($urandom % 10 == 0) : ($urandom % 2 == 0);
            exp_w = (m_owner >= 0 && wr_en) ? 4'(1 << m_owner) : 4'd0;
            exp_d = (m_owner >= 0 && done) ? 4'(1 << m_owner) : 4'd0;
            #1;
            total++; if (mem_ready_a !== (m_owner >= 0)) begin bad++; $display("FAIL rnd_mem_ready cyc=%0d got=%0b exp=%0b", cyc, mem_ready_a, m_owner >= 0); end
            if (m_owner >= 0) begin
                total++; if (sel_a !== 2'(m_owner)) begin bad++; $display("FAIL rnd_sel cyc=%0d got=%0d exp=%0d", cyc, sel_a, m_owner); end
            end
            total++; if (wr_en_out_a !== exp_w || done_out_a !== exp_d) begin bad++; $display("FAIL rnd_route cyc=%0d got=%0h/%0h exp=%0h/%0h", cyc, wr_en_out_a, done_out_a, exp_w, exp_d); end
            total++; if (wr_addr_out_a !== wr_addr || wr_data_out_a !== wr_data) begin bad++; $display("FAIL rnd_bcast cyc=%0d got=%0h/%0h", cyc, wr_addr_out_a, wr_data_out_a); end
            total++; if (order_valid_a !== (m_q.size() > 0)) begin bad++; $display("FAIL rnd_order_valid cyc=%0d got=%0b exp=%0b", cyc, order_valid_a, m_q.size() > 0); end
            if (m_q.size() > 0) begin
                total++; if (order_id_a !== 2'(m_q[0])) begin bad++; $display("FAIL rnd_order_id cyc=%0d got=%0d exp=%0d", cyc, order_id_a, m_q[0]); end
            end
            total++; if (drop_count_a !== 16'(m_drops)) begin bad++; $display("FAIL rnd_drops cyc=%0d got=%0d exp=%0d", cyc, drop_count_a, m_drops); end
            @(posedge clk);
            model_step(mem_ready_in, done, order_rd_en);
        end
        @(negedge clk);
        wr_en = 1'b0; done = 1'b0; order_rd_en = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; done = 1'b0; mem_ready_in = 4'd0; order_rd_en = 1'b0;
        wr_addr = 10'd0; wr_data = 64'd0;
        model_reset();
        test_reset();
        test_round_robin();
        test_ready_drop();
        test_pessimistic();
        test_capacity();
        test_drops();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
